// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Optional error-count output is enabled with SWEEP_ERRCOUNT_EN.
package sweep_pkg;

    localparam int N_VARS  = 4;
    localparam int TABLE_W = 16;

    // Golden table of the SoP decoder with minterms 0,1,5,6,8,9,C,E.
    localparam logic [TABLE_W-1:0] DEFAULT_EXPECTED = 16'h5363;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/sweep_popcount16.sv
// Combinational population count of a 16-bit vector (0..16).
// Used only when SWEEP_ERRCOUNT_EN is defined.
module sweep_popcount16
    import sweep_pkg::*;
(
    input  logic [TABLE_W-1:0] vec,
    output logic [4:0]         count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < TABLE_W; i++) begin
            count = count + 5'(vec[i]);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked sweep of all 16 minterms into a 4-input decoder, capturing and grading its truth table.
// Define SWEEP_ERRCOUNT_EN to add the err_count output (mismatching bit count).
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int                 SETTLE   = 1,
    parameter logic [TABLE_W-1:0] EXPECTED = DEFAULT_EXPECTED
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                s,
    output logic                a,
    output logic                b,
    output logic                c,
    output logic                d,
    output logic [N_VARS-1:0]   m,
    output logic [TABLE_W-1:0]  table_out,
    output logic                busy,
    output logic                done,
    output logic                match
`ifdef SWEEP_ERRCOUNT_EN
    ,
    output logic [4:0]          err_count
`endif
);

    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [N_VARS-1:0] LAST_M      = N_VARS'(TABLE_W - 1);

    sweep_state_t        state, state_next;
    logic [N_VARS-1:0]   m_q, m_next;
    logic [3:0]          cnt_q, cnt_next;
    logic [TABLE_W-1:0]  table_q, table_next;
    logic                match_q, match_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            m_q     <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            match_q <= 1'b0;
        end else begin
            state   <= state_next;
            m_q     <= m_next;
            cnt_q   <= cnt_next;
            table_q <= table_next;
            match_q <= match_next;
        end
    end

    // Each minterm spends SETTLE cycles in DRIVE and one in SAMPLE; m stops at 15.
    always_comb begin
        state_next = state;
        m_next     = m_q;
        cnt_next   = cnt_q;
        table_next = table_q;
        match_next = match_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRIVE;
                    m_next     = '0;
                    cnt_next   = '0;
                    table_next = '0;
                    match_next = 1'b0;
                end
            end
            DRIVE: begin
                cnt_next = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                table_next[m_q] = s;
                if (m_q == LAST_M) begin
                    state_next = DONE;
                end else begin
                    m_next     = m_q + 1'b1;
                    cnt_next   = '0;
                    state_next = DRIVE;
                end
            end
            DONE: begin
                match_next = (table_q == EXPECTED);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef SWEEP_ERRCOUNT_EN
    logic [4:0] pop_count;
    logic [4:0] err_q;

    sweep_popcount16 u_popcount (
        .vec   (table_q ^ EXPECTED),
        .count (pop_count)
    );

    // Graded alongside match so both describe the same completed table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (state == IDLE && start) begin
            err_q <= '0;
        end else if (state == DONE) begin
            err_q <= pop_count;
        end
    end

    assign err_count = err_q;
`endif

    assign {a, b, c, d} = m_q;
    assign m            = m_q;
    assign table_out    = table_q;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign match        = match_q;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage upstream of the 4-input SoP decoder (minterm set 0,1,5,6,8,9,C,E).
- On a start pulse, drives a,b,c,d through minterms 0..F in order and samples the decoder output s after a settle delay.
- Assembles the 16-bit truth table and compares it with an expected constant.
- Replaces the hand-written #1 sweep with a clocked, self-checking sequencer usable on hardware.

Parameters:
- SETTLE, 1: cycles each minterm is held before s is sampled; legal range 1..15.
- EXPECTED, 16'h5363: golden truth table; bit i is the expected s for minterm i.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- s  input  1  decoder output under test.
- a  output  1  minterm bit 3 (MSB).
- b  output  1  minterm bit 2.
- c  output  1  minterm bit 1.
- d  output  1  minterm bit 0 (LSB).
- m  output  4  current minterm index; equals {a,b,c,d}.
- table_out  output  16  captured truth table; bit i = s sampled at minterm i.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse when the sweep completes.
- match  output  1  table_out == EXPECTED; valid from done, held until the next start.

Behaviour:
- Reset values: a=b=c=d=0, m=0, table_out=0, busy=0, done=0, match=0, state=IDLE, settle counter=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 leads to DRIVE.
  - On the same edge: m<=0, table_out<=0, match<=0, settle counter<=0.
- DRIVE:
  - {a,b,c,d} = m, registered.
  - Settle counter increments each cycle.
  - When counter reaches SETTLE-1, go to SAMPLE.
- SAMPLE:
  - table_out[m] <= s.
  - If m==15, go to DONE.
  - Otherwise m<=m+1, counter<=0, go to DRIVE.
- DONE:
  - done=1 for exactly one cycle.
  - match <= (table_out == EXPECTED), using the fully captured table.
  - Next state is IDLE.
- Latency: start sampled at edge 0; done is high in cycle 16*(SETTLE+1)+1. This is 33 cycles for SETTLE=1.
- busy=1 in DRIVE, SAMPLE and DONE.
- start while busy is ignored: no restart, no queuing.
- start in the DONE cycle is also ignored.
- start in the cycle after DONE begins a new sweep.
- m never wraps inside a sweep. After DONE, m holds 15 and the outputs hold {1,1,1,1} until the next start.
- s is sampled only in SAMPLE; its value in other states is don't-care.
- Asynchronous reset mid-sweep:
  - All outputs return to reset values immediately.
  - The partial table is discarded.
  - No done pulse is produced.
- table_out is stable (no partial updates) outside a sweep.

Optional Feature:
- Macro: SWEEP_ERRCOUNT_EN.
- Defined:
  - Adds output err_count [4:0] = popcount(table_out ^ EXPECTED).
  - Registered in DONE, alongside match.
  - Reset and start clear it to 0.
  - Range 0..16.
- Undefined:
  - Port absent, no popcount logic.
  - All other behaviour identical.

Decomposition:
- Package sweep_pkg:
  - state enum (IDLE, DRIVE, SAMPLE, DONE).
  - N_VARS=4.
  - TABLE_W=16.
  - Default EXPECTED constant 16'h5363.
- One natural sub-module: sweep_popcount16, combinational popcount. Instantiated only under SWEEP_ERRCOUNT_EN.
- The DUT decoder is instantiated by the bench, not inside this block.

Test Plan:
- Correct decoder:
  - Stimulus: reset, then start pulse, SETTLE=1, s driven by a correct SoP model.
  - Expected: done in cycle 33, table_out=16'h5363, match=1, err_count=0.
- Stuck-at-0 decoder:
  - Stimulus: s tied 0.
  - Expected: table_out=16'h0000, match=0, err_count=8.
- Single faulty minterm:
  - Stimulus: decoder inverted at minterm 7 only.
  - Expected: table_out=16'h53E3, match=0, err_count=1.
- Ignored restart:
  - Stimulus: start re-asserted at cycles 5 and 20 of a sweep.
  - Expected: no restart; single done at cycle 33; m sequence 0..15 monotonic.
- Reset mid-sweep:
  - Stimulus: reset asserted asynchronously (between edges) at m=9.
  - Expected: outputs zero immediately, no done pulse; next start yields a full correct sweep.
- Longer settle:
  - Stimulus: SETTLE=3 with a correct decoder.
  - Expected: each minterm held 3 cycles before sampling; done at cycle 65; match=1.
